// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the block-granular memory models: FSM encoding
// and geometry helpers derived from block/memory size parameters.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'h0,
    WAIT = 2'h1,
    ACK  = 2'h2
  } mem_state_e;

  function automatic int block_bits(input int block_size);
    return block_size * 8;
  endfunction

  function automatic int offset_bits(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int block_count(input int memory_size, input int block_size);
    return memory_size / block_size;
  endfunction

  // Index width is kept at least one bit so a single-block memory still elaborates.
  function automatic int index_bits(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // Geometry of the default configuration (32-byte blocks, 1 KiB).
  localparam int pBlockBits  = block_bits(32);
  localparam int pOffsetBits = offset_bits(32);
  localparam int pBlockCount = block_count(1024, 32);

endpackage

// File: rtl/mem_latency_counter.sv
// Load/decrement counter with a done flag, used to model fixed memory access latency.
module mem_latency_counter #(
  parameter int pWidth = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [pWidth-1:0] load_value,
  input  logic              dec,
  output logic              done
);

  logic [pWidth-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Done marks the final wait edge, when the access itself is performed.
  assign done = (count == pWidth'(1));

endmodule

// File: rtl/block_data_memory.sv
// Block-granular backing memory answering cache line fills and write-backs
// after a fixed access latency, with a one-cycle acknowledge.
//
//   state | meaning
//   IDLE  | waiting for req_i; request fields are latched on acceptance
//   WAIT  | latency countdown; access performed on the edge the counter hits 1
//   ACK   | ack_o pulse, busy_o still high; returns to IDLE next edge
module block_data_memory
  import cpu_mem_pkg::*;
#(
  parameter int pBlockSize  = 32,
  parameter int pMemorySize = 1024,
  parameter int pAddrWidth  = 32,
  parameter int pLatency    = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    write_ctrl_i,
  input  logic [pAddrWidth-1:0]   addr_i,
  input  logic [pBlockSize*8-1:0] write_data_i,
  output logic                    ack_o,
  output logic [pBlockSize*8-1:0] read_data_o,
  output logic                    busy_o
);

  localparam int lBlockBits  = block_bits(pBlockSize);
  localparam int lOffsetBits = offset_bits(pBlockSize);
  localparam int lBlockCount = block_count(pMemorySize, pBlockSize);
  localparam int lIdxWidth   = index_bits(lBlockCount);
  localparam int lCntWidth   = $clog2(pLatency + 1);

  logic [lBlockBits-1:0] memory [lBlockCount];

  mem_state_e            state;
  mem_state_e            state_next;
  logic                  accept;
  logic                  access;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_done;
  logic                  wr_q;
  logic [lIdxWidth-1:0]  idx_q;
  logic [lBlockBits-1:0] wdata_q;
  logic [lIdxWidth-1:0]  idx_in;
  logic                  acc_wr;
  logic [lIdxWidth-1:0]  acc_idx;
  logic [lBlockBits-1:0] acc_data;

  // Out-of-range addresses wrap onto the array.
  assign idx_in = lIdxWidth'((addr_i >> lOffsetBits) % pAddrWidth'(lBlockCount));

  mem_latency_counter #(
    .pWidth (lCntWidth)
  ) u_latency (
    .clk        (clk_i),
    .rst        (rst_i),
    .load       (cnt_load),
    .load_value (lCntWidth'(pLatency - 1)),
    .dec        (cnt_dec),
    .done       (cnt_done)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    access     = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          if (pLatency == 1) begin
            access     = 1'b1;
            state_next = ACK;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) begin
          access     = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // An access from IDLE only happens with single-cycle latency, using live inputs.
  assign acc_wr   = (state == IDLE) ? write_ctrl_i : wr_q;
  assign acc_idx  = (state == IDLE) ? idx_in       : idx_q;
  assign acc_data = (state == IDLE) ? write_data_i : wdata_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      read_data_o <= '0;
    end else begin
      state <= state_next;
      if (access && !acc_wr) begin
        read_data_o <= memory[acc_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      wr_q    <= write_ctrl_i;
      idx_q   <= idx_in;
      wdata_q <= write_data_i;
    end
  end

  // The array is never cleared; reset only blocks a pending commit.
  always_ff @(posedge clk_i) begin
    if (rst_i && access && acc_wr) begin
      memory[acc_idx] <= acc_data;
    end
  end

  assign ack_o  = (state == ACK);
  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_block_data_memory.sv
// Scoreboard bench for block_data_memory: stimulus queues expected acks,
// a negedge monitor checks ack timing and read data as they appear.
module tb_block_data_memory;

  localparam int LAT = 10;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         req_i = 1'b0;
  logic         write_ctrl_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic [255:0] write_data_i = '0;
  logic         ack_o;
  logic [255:0] read_data_o;
  logic         busy_o;

  block_data_memory dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .write_ctrl_i (write_ctrl_i),
    .addr_i       (addr_i),
    .write_data_i (write_data_i),
    .ack_o        (ack_o),
    .read_data_o  (read_data_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // cyc equals the number of the most recent rising edge when sampled at negedge.
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [255:0] data;
    int           ack_edge;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  localparam logic [255:0] MEM2 = 256'h0000_0005_0000_0003;
  localparam logic [255:0] BEEF = 256'hDEAD_BEEF;

  function automatic logic [255:0] pre(input int i);
    logic [31:0] w;
    w = 32'hA000_0000 + 32'(i);
    return {8{w}};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (ack_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ack actual=ack after edge %0d required=no ack", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("ack_edge", 256'(cyc), 256'(mon_e.ack_edge));
        check("busy_in_ack", 256'(busy_o), 256'd1);
        check("read_data", read_data_o, mon_e.data);
      end
    end
  end

  // Drive a request at a negedge; acceptance is the next rising edge N, and the
  // ack appears after edge N+LAT-1 (cycle N+LAT). Returns at the negedge after N with req still high.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [255:0] d,
                       input logic expect_ack, input logic [255:0] exp_rd, output int n);
    req_i        = 1'b1;
    write_ctrl_i = wr;
    addr_i       = a;
    write_data_i = d;
    n = cyc + 1;
    if (expect_ack) sb.push_back('{exp_rd, n + LAT - 1});
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy_o; i++) @(negedge clk_i);
    check("idle_timeout", 256'(busy_o), 256'd0);
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) dut.memory[i] <= pre(i);
    dut.memory[2] <= MEM2;

    // Reset held with a pending write request.
    rst_i = 1'b0; req_i = 1'b1; write_ctrl_i = 1'b1; addr_i = 32'h20; write_data_i = '1;
    repeat (3) @(negedge clk_i);
    check("rst_ack", 256'(ack_o), 256'd0);
    check("rst_busy", 256'(busy_o), 256'd0);
    check("rst_rdata", read_data_o, 256'd0);
    check("rst_mem1", dut.memory[1], pre(1));
    req_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);

    // Read latency.
    issue(1'b0, 32'h40, '0, 1'b1, MEM2, n);
    req_i = 1'b0;
    check("busy_after_accept", 256'(busy_o), 256'd1);
    repeat (4) @(negedge clk_i);
    check("busy_mid_wait", 256'(busy_o), 256'd1);
    wait_idle();

    // Write with offset bits set; read data must hold the previous read.
    issue(1'b1, 32'h64, BEEF, 1'b1, MEM2, n);
    req_i = 1'b0;
    wait_idle();
    check("write_mem3", dut.memory[3], BEEF);
    issue(1'b0, 32'h60, '0, 1'b1, BEEF, n);
    req_i = 1'b0;
    wait_idle();

    // Latched inputs; req pulse during WAIT is ignored.
    issue(1'b0, 32'h80, '0, 1'b1, pre(4), n);
    addr_i = 32'h0; write_ctrl_i = 1'b1; write_data_i = '1;
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    req_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b0;
    wait_idle();
    check("latch_mem0", dut.memory[0], pre(0));

    // Wrap-around and back-to-back acceptance with req held through ack.
    issue(1'b0, 32'h400, '0, 1'b1, pre(0), n);
    addr_i = 32'h420;
    sb.push_back('{pre(1), n + 11 + LAT - 1});
    repeat (11) @(negedge clk_i);
    req_i = 1'b0;
    check("b2b_busy", 256'(busy_o), 256'd1);
    wait_idle();

    // Reset in the middle of a write to index 1.
    issue(1'b1, 32'h20, 256'h1234, 1'b0, '0, n);
    req_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    check("midrst_busy", 256'(busy_o), 256'd0);
    check("midrst_rdata", read_data_o, 256'd0);
    repeat (15) @(negedge clk_i);
    check("midrst_mem1", dut.memory[1], pre(1));
    issue(1'b0, 32'h20, '0, 1'b1, pre(1), n);
    req_i = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk_i);
    check("scoreboard_drained", 256'(sb.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
